// File: rtl/ni_pkg.sv
// Shared types and defaults for the spike network interface.
// Optional packet counter is enabled with NI_PKT_COUNT_EN.
package ni_pkg;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned PTR_W    = 5;
    localparam int unsigned MAX_CONN = 30;

    localparam int unsigned SRC_MSB = 23;
    localparam int unsigned DST_MSB = 11;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        EMIT
    } state_t;

endpackage

// File: rtl/lowest_set_index.sv
// Priority encoder: index of the lowest set bit of vec, plus an any-set flag.
module lowest_set_index #(
    parameter int unsigned N     = 10,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i] && !any) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_network_interface.sv
// Walks the CSR connection list of each spiking neuron and emits {src, dst} packets.
// Define NI_PKT_COUNT_EN to add the saturating pkt_count output.
module spike_network_interface
    import ni_pkg::*;
#(
    parameter int unsigned N_NEURONS = 10,
    parameter int unsigned ADDR_W    = ni_pkg::ADDR_W,
    parameter int unsigned PTR_W     = ni_pkg::PTR_W,
    parameter int unsigned MAX_CONN  = ni_pkg::MAX_CONN
) (
    input  logic                            CLK,
    input  logic                            clear,
    input  logic                            spike0,
    input  logic                            spike1,
    input  logic                            spike2,
    input  logic                            spike3,
    input  logic                            spike4,
    input  logic                            spike5,
    input  logic                            spike6,
    input  logic                            spike7,
    input  logic                            spike8,
    input  logic                            spike9,
    input  logic [N_NEURONS*ADDR_W-1:0]     neuron_addresses_initialization,
    input  logic [(N_NEURONS+1)*PTR_W-1:0]  connection_pointer_initialization,
    input  logic [MAX_CONN*ADDR_W-1:0]      downstream_connections_initialization,
    output logic [2*ADDR_W-1:0]             packet,
    output logic                            packet_valid
`ifdef NI_PKT_COUNT_EN
    ,
    output logic [15:0]                     pkt_count
`endif
);

    localparam int unsigned IDX_W  = $clog2(N_NEURONS);
    localparam int unsigned IDX1_W = $clog2(N_NEURONS + 1);
    localparam logic [PTR_W:0] LAST = (PTR_W + 1)'(MAX_CONN);

    logic [ADDR_W-1:0] addr [N_NEURONS];
    logic [PTR_W-1:0]  ptr  [N_NEURONS+1];
    logic [ADDR_W-1:0] conn [MAX_CONN];

    always_comb begin
        for (int unsigned k = 0; k < N_NEURONS; k++)
            addr[k] = neuron_addresses_initialization[N_NEURONS*ADDR_W-1-ADDR_W*k -: ADDR_W];
        for (int unsigned k = 0; k < N_NEURONS + 1; k++)
            ptr[k] = connection_pointer_initialization[(N_NEURONS+1)*PTR_W-1-PTR_W*k -: PTR_W];
        for (int unsigned j = 0; j < MAX_CONN; j++)
            conn[j] = downstream_connections_initialization[MAX_CONN*ADDR_W-1-ADDR_W*j -: ADDR_W];
    end

    logic [N_NEURONS-1:0] spike_vec;
    assign spike_vec = {spike9, spike8, spike7, spike6, spike5,
                        spike4, spike3, spike2, spike1, spike0};

    state_t               state, state_n;
    logic [N_NEURONS-1:0] pending, pending_n;
    logic [N_NEURONS-1:0] served, served_n;
    logic [PTR_W-1:0]     cursor, cursor_n;
    logic [PTR_W-1:0]     walk_end, walk_end_n;
    logic [IDX_W-1:0]     sel, sel_n;
    logic [2*ADDR_W-1:0]  packet_n;
    logic                 packet_valid_n;

    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_any;
    logic [N_NEURONS-1:0] sel_mask;
    logic [PTR_W-1:0]     sel_start, sel_stop;
    logic                 has_entries;
    logic [PTR_W:0]       cursor_inc;

    lowest_set_index #(
        .N     (N_NEURONS),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec (pending),
        .idx (sel_idx),
        .any (sel_any)
    );

    assign sel_mask    = N_NEURONS'(1) << sel_idx;
    assign sel_start   = ptr[IDX1_W'(sel_idx)];
    assign sel_stop    = ptr[IDX1_W'(sel_idx) + IDX1_W'(1)];
    assign has_entries = (sel_stop > sel_start) && ({1'b0, sel_start} < LAST);
    assign cursor_inc  = {1'b0, cursor} + {{PTR_W{1'b0}}, 1'b1};

    always_comb begin
        state_n        = state;
        // Spikes landing this edge are visible to the IDLE decision immediately.
        pending_n      = pending | (spike_vec & ~served);
        served_n       = served;
        cursor_n       = cursor;
        walk_end_n     = walk_end;
        sel_n          = sel;
        packet_n       = packet;
        packet_valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (pending_n != '0)
                    state_n = SELECT;
            end
            SELECT: begin
                if (sel_any) begin
                    pending_n  = pending_n & ~sel_mask;
                    served_n   = served | sel_mask;
                    cursor_n   = sel_start;
                    walk_end_n = sel_stop;
                    sel_n      = sel_idx;
                    state_n    = has_entries ? EMIT : IDLE;
                end else begin
                    state_n = IDLE;
                end
            end
            EMIT: begin
                packet_n[SRC_MSB -: ADDR_W] = addr[sel];
                packet_n[DST_MSB -: ADDR_W] = conn[cursor];
                packet_valid_n = 1'b1;
                cursor_n       = cursor_inc[PTR_W-1:0];
                if (cursor_inc == {1'b0, walk_end} || cursor_inc == LAST)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            state        <= IDLE;
            pending      <= '0;
            served       <= '0;
            cursor       <= '0;
            walk_end     <= '0;
            sel          <= '0;
            packet       <= '0;
            packet_valid <= 1'b0;
        end else begin
            state        <= state_n;
            pending      <= pending_n;
            served       <= served_n;
            cursor       <= cursor_n;
            walk_end     <= walk_end_n;
            sel          <= sel_n;
            packet       <= packet_n;
            packet_valid <= packet_valid_n;
        end
    end

`ifdef NI_PKT_COUNT_EN
    always_ff @(posedge CLK or posedge clear) begin
        if (clear)
            pkt_count <= '0;
        else if (state == EMIT && pkt_count != '1)
            pkt_count <= pkt_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_spike_network_interface.sv
// Randomized and scenario bench for spike_network_interface against an event-scheduling model.
module tb_spike_network_interface;

    logic         CLK = 1'b0;
    logic         clear = 1'b1;
    logic [9:0]   spk = '0;
    logic [119:0] nai;
    logic [54:0]  cpi;
    logic [359:0] dci;
    logic [23:0]  packet;
    logic         packet_valid;
`ifdef NI_PKT_COUNT_EN
    logic [15:0]  pkt_count;
`endif

    always #5 CLK = ~CLK;

    spike_network_interface dut (
        .CLK                                   (CLK),
        .clear                                 (clear),
        .spike0                                (spk[0]),
        .spike1                                (spk[1]),
        .spike2                                (spk[2]),
        .spike3                                (spk[3]),
        .spike4                                (spk[4]),
        .spike5                                (spk[5]),
        .spike6                                (spk[6]),
        .spike7                                (spk[7]),
        .spike8                                (spk[8]),
        .spike9                                (spk[9]),
        .neuron_addresses_initialization       (nai),
        .connection_pointer_initialization     (cpi),
        .downstream_connections_initialization (dci),
        .packet                                (packet),
        .packet_valid                          (packet_valid)
`ifdef NI_PKT_COUNT_EN
        ,
        .pkt_count                             (pkt_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    int addr_c [10];
    int ptr_c  [11];
    int conn_c [30];

    // Model: pending/served sets and a map from edge number to the packet due then.
    int          edge_no = 0;
    int          decide  = 1;
    bit [9:0]    m_pend, m_served;
    logic [23:0] sched [int];
    logic [23:0] m_pkt = '0;
    logic        exp_valid = 1'b0;
    int          m_cnt = 0;
    logic [23:0] obs [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic pack_cfg();
        for (int k = 0; k < 10; k++) nai[119-12*k -: 12] = 12'(addr_c[k]);
        for (int k = 0; k < 11; k++) cpi[54-5*k -: 5] = 5'(ptr_c[k]);
        for (int j = 0; j < 30; j++) dci[359-12*j -: 12] = 12'(conn_c[j]);
    endtask

    task automatic model_edge(input logic [9:0] sp, input logic clr);
        int k;
        int n;
        edge_no++;
        if (clr) begin
            m_pend   = '0;
            m_served = '0;
            m_pkt    = '0;
            m_cnt    = 0;
            sched.delete();
            decide    = edge_no + 1;
            exp_valid = 1'b0;
        end else begin
            m_pend |= sp & ~m_served;
            if (edge_no == decide) begin
                decide = edge_no + 1;
                if (m_pend != 0) begin
                    k = -1;
                    for (int i = 0; i < 10; i++)
                        if (m_pend[i] && k < 0) k = i;
                    m_pend[k]   = 1'b0;
                    m_served[k] = 1'b1;
                    n = 0;
                    for (int j = ptr_c[k]; j < ptr_c[k+1] && j < 30; j++) begin
                        sched[edge_no + 2 + n] = {12'(addr_c[k]), 12'(conn_c[j])};
                        n++;
                    end
                    decide = edge_no + 2 + n;
                end
            end
            exp_valid = sched.exists(edge_no);
            if (exp_valid) begin
                m_pkt = sched[edge_no];
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic [9:0] sp, input logic clr);
        @(negedge CLK);
        spk   = sp;
        clear = clr;
        if (clr) begin
            #1;
            check("clr_async_pkt", 32'(packet), 32'h0);
            check("clr_async_vld", 32'(packet_valid), 32'h0);
        end
        @(posedge CLK);
        model_edge(sp, clr);
        #1;
        check("valid", 32'(packet_valid), 32'(exp_valid));
        check("packet", 32'(packet), 32'(m_pkt));
`ifdef NI_PKT_COUNT_EN
        check("pkt_count", 32'(pkt_count), 32'(m_cnt));
`endif
        if (packet_valid) obs.push_back(packet);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0);
    endtask

    task automatic expect_log(input string tag, input logic [23:0] exp [$]);
        check({tag, "_len"}, 32'(obs.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            check(tag, 32'(obs[i]), 32'(exp[i]));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int conn_init [19] = '{3, 5, 7, 4, 6, 4, 5, 6, 8, 9, 8, 9, 8, 9, 9, 8, 9, 'hFFB, 'hFFC};
        int ptr_init  [11] = '{0, 3, 5, 8, 10, 12, 14, 15, 17, 18, 19};
        bit found;
        for (int k = 0; k < 10; k++) addr_c[k] = k;
        for (int k = 0; k < 11; k++) ptr_c[k] = ptr_init[k];
        for (int j = 0; j < 30; j++) conn_c[j] = (j < 19) ? conn_init[j] : 0;
        pack_cfg();

        #2;
        check("reset_pkt", 32'(packet), 32'h0);
        check("reset_vld", 32'(packet_valid), 32'h0);
        step('0, 1'b1);
        run_idle(3);

        obs.delete();
        step(10'b0000000001, 1'b0);
        run_idle(8);
        expect_log("s0", '{24'h000003, 24'h000005, 24'h000007});

        step('0, 1'b1);
        obs.delete();
        step(10'b0001000100, 1'b0);
        run_idle(12);
        expect_log("s2_6", '{24'h002004, 24'h002005, 24'h002006, 24'h006009});

        step('0, 1'b1);
        obs.delete();
        for (int i = 0; i < 20; i++) step(10'b0100000000, 1'b0);
        expect_log("s8_held", '{24'h008FFB});
        obs.delete();
        step(10'b0100000000, 1'b1);
        for (int i = 0; i < 6; i++) step(10'b0100000000, 1'b0);
        run_idle(2);
        expect_log("s8_reclr", '{24'h008FFB});

        step('0, 1'b1);
        obs.delete();
        step(10'b0000000001, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step('0, 1'b0);
            if (packet_valid && packet == 24'h000003) found = 1'b1;
        end
        check("wait_pkt3", 32'(found), 32'h1);
        obs.delete();
        step('0, 1'b1);
        run_idle(6);
        expect_log("s0_abort", '{});

        ptr_c[3] = 10;
        pack_cfg();
        step('0, 1'b1);
        obs.delete();
        step(10'b0000001000, 1'b0);
        run_idle(6);
        expect_log("s3_empty", '{});
        ptr_c[3] = 8;
        pack_cfg();

        step('0, 1'b1);
        obs.delete();
        step(10'h3FF, 1'b0);
        run_idle(45);
        check("all_count", 32'(obs.size()), 32'd19);
`ifdef NI_PKT_COUNT_EN
        check("all_pkt_count", 32'(pkt_count), 32'd19);
`endif
        step('0, 1'b1);
`ifdef NI_PKT_COUNT_EN
        check("pkt_count_clr", 32'(pkt_count), 32'd0);
`endif

        for (int i = 0; i < 500; i++) begin
            logic [9:0] sp;
            logic       clr;
            sp  = ($urandom_range(0, 5) == 0) ? 10'($urandom) : 10'h0;
            clr = ($urandom_range(0, 49) == 0);
            step(sp, clr);
        end
        run_idle(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
